// File: rtl/wb_trace_buffer_pkg.sv
// Shared types and constants for the writeback retirement trace buffer.
package wb_trace_buffer_pkg;

  localparam int unsigned TRACE_SEQ_W = 16;
  localparam logic [7:0]  TRACE_DROP_MAX = 8'd255;

  typedef struct packed {
    logic [TRACE_SEQ_W-1:0] seq;
    logic [4:0]             addr;
    logic [31:0]            data;
  } wb_trace_s;

endpackage

// File: rtl/wb_trace_buffer_trace_fifo.sv
// Fall-through FIFO over a generic element type; owns pointers, occupancy and
// the clear > push/pop priority.
module trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter type         T     = logic [31:0]
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  T                mem [DEPTH];
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   wptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback retirement trace: sequence-numbered record FIFO plus a shadow copy
// of the architectural register file.
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned SEQ_W     = 16,
  parameter bit          FILTER_X0 = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   wb_e,
  input  logic [4:0]             wb_a,
  input  logic [31:0]            wb_d,
  output logic                   tr_valid,
  input  logic                   tr_ready,
  output logic [SEQ_W-1:0]       tr_seq,
  output logic [4:0]             tr_addr,
  output logic [31:0]            tr_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  input  logic [4:0]             sh_addr,
  output logic [31:0]            sh_data
);

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [4:0]       addr;
    logic [31:0]      data;
  } rec_t;

  logic [SEQ_W-1:0] seq;
  logic [31:0]      shadow [32];
  logic             retire;
  logic             shadow_we;
  logic             pop;
  logic             full;
  logic             empty;
  logic             drop;
  rec_t             push_rec;
  rec_t             head;

  assign retire    = wb_e && !(FILTER_X0 && (wb_a == '0));
  assign shadow_we = retire && (wb_a != '0);
  assign pop       = tr_valid && tr_ready;
  assign drop      = retire && !clear && full && !pop;
  assign push_rec  = '{seq: seq, addr: wb_a, data: wb_d};

  trace_fifo #(
    .DEPTH (DEPTH),
    .T     (rec_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (retire),
    .push_data (push_rec),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign tr_valid = !empty;
  assign tr_seq   = head.seq;
  assign tr_addr  = head.addr;
  assign tr_data  = head.data;

  // Sequence advances on every retire, including dropped and cleared ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (retire) seq <= seq + SEQ_W'(1);
      if (clear) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != TRACE_DROP_MAX) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_data <= '0;
      for (int unsigned i = 0; i < 32; i++) shadow[i] <= '0;
    end else begin
      if (shadow_we) shadow[wb_a] <= wb_d;
      if (sh_addr == '0)                     sh_data <= '0;
      else if (shadow_we && wb_a == sh_addr) sh_data <= wb_d;
      else                                   sh_data <= shadow[sh_addr];
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer (DEPTH=8, SEQ_W=16, FILTER_X0=1).
module tb_wb_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        wb_e = 1'b0;
  logic [4:0]  wb_a = '0;
  logic [31:0] wb_d = '0;
  logic        tr_valid;
  logic        tr_ready = 1'b0;
  logic [15:0] tr_seq;
  logic [4:0]  tr_addr;
  logic [31:0] tr_data;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic [4:0]  sh_addr = '0;
  logic [31:0] sh_data;

  int checks = 0;
  int failures = 0;

  wb_trace_buffer #(
    .DEPTH     (8),
    .SEQ_W     (16),
    .FILTER_X0 (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .wb_e     (wb_e),
    .wb_a     (wb_a),
    .wb_d     (wb_d),
    .tr_valid (tr_valid),
    .tr_ready (tr_ready),
    .tr_seq   (tr_seq),
    .tr_addr  (tr_addr),
    .tr_data  (tr_data),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .sh_addr  (sh_addr),
    .sh_data  (sh_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wb_e = 1'b0; clear = 1'b0; tr_ready = 1'b0; sh_addr = '0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic retire(input logic [4:0] a, input logic [31:0] d);
    wb_e = 1'b1; wb_a = a; wb_d = d;
    step();
    wb_e = 1'b0;
  endtask

  initial begin
    // Reset state, checked while reset is still held
    reset = 1'b1;
    #2;
    check("rst_valid", 64'(tr_valid), 64'd0);
    check("rst_seq",   64'(tr_seq),   64'd0);
    check("rst_data",  64'(tr_data),  64'd0);
    check("rst_count", 64'(count),    64'd0);
    check("rst_ovf",   64'(overflow), 64'd0);
    check("rst_drop",  64'(drop_cnt), 64'd0);
    check("rst_sh",    64'(sh_data),  64'd0);
    reset = 1'b0;
    step();

    // Streaming with tr_ready=1
    tr_ready = 1'b1;
    wb_e = 1'b1; wb_a = 5'd1; wb_d = 32'h11;
    step();
    check("s1_valid", 64'(tr_valid), 64'd1);
    check("s1_seq",   64'(tr_seq),   64'd0);
    check("s1_addr",  64'(tr_addr),  64'd1);
    check("s1_data",  64'(tr_data),  64'h11);
    check("s1_count", 64'(count),    64'd1);
    wb_a = 5'd2; wb_d = 32'h22;
    step();
    check("s2_seq",   64'(tr_seq),   64'd1);
    check("s2_data",  64'(tr_data),  64'h22);
    check("s2_count", 64'(count),    64'd1);
    wb_a = 5'd3; wb_d = 32'h33;
    step();
    check("s3_seq",   64'(tr_seq),   64'd2);
    check("s3_data",  64'(tr_data),  64'h33);
    check("s3_count", 64'(count),    64'd1);
    wb_e = 1'b0;
    step();
    check("s4_valid", 64'(tr_valid), 64'd0);
    check("s4_count", 64'(count),    64'd0);

    // Overflow: 10 events into 8 entries
    do_reset();
    for (int i = 0; i < 10; i++) retire(5'(i + 1), 32'h100 + 32'(i));
    check("ov_count", 64'(count),    64'd8);
    check("ov_flag",  64'(overflow), 64'd1);
    check("ov_drop",  64'(drop_cnt), 64'd2);
    tr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("ov_drain_seq",  64'(tr_seq),  64'(i));
      check("ov_drain_data", 64'(tr_data), 64'(32'h100 + 32'(i)));
      step();
    end
    check("ov_empty", 64'(count), 64'd0);
    tr_ready = 1'b0;
    retire(5'd4, 32'h44);
    check("ov_gap_seq", 64'(tr_seq), 64'd10);
    tr_ready = 1'b1;
    step();
    tr_ready = 1'b0;
    check("ov_after_count", 64'(count), 64'd0);

    // x0 filter and shadow file
    sh_addr = 5'd0;
    retire(5'd0, 32'hDEAD);
    check("x0_count", 64'(count),   64'd0);
    check("x0_sh",    64'(sh_data), 64'd0);
    sh_addr = 5'd5;
    retire(5'd5, 32'hCAFE);
    check("wf_sh",    64'(sh_data), 64'hCAFE);
    check("x0_seq",   64'(tr_seq),  64'd11);
    check("wf_count", 64'(count),   64'd1);
    sh_addr = 5'd10;
    step();
    check("sh_dropped_rec", 64'(sh_data), 64'h109);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) retire(5'(i + 1), 32'h200 + 32'(i));
    check("fp_full", 64'(count), 64'd8);
    tr_ready = 1'b1;
    retire(5'd20, 32'hABC);
    check("fp_count", 64'(count),    64'd8);
    check("fp_ovf",   64'(overflow), 64'd0);
    check("fp_head",  64'(tr_seq),   64'd1);
    for (int i = 1; i <= 8; i++) begin
      check("fp_drain_seq", 64'(tr_seq), 64'(i));
      if (i == 8) begin
        check("fp_last_addr", 64'(tr_addr), 64'd20);
        check("fp_last_data", 64'(tr_data), 64'hABC);
      end
      step();
    end
    check("fp_empty", 64'(count), 64'd0);
    tr_ready = 1'b0;

    // Clear with 4 entries and overflow set; retire in the same cycle
    do_reset();
    for (int i = 0; i < 10; i++) retire(5'd1, 32'(i));
    tr_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    tr_ready = 1'b0;
    check("cl_pre_count", 64'(count),    64'd4);
    check("cl_pre_ovf",   64'(overflow), 64'd1);
    clear = 1'b1; sh_addr = 5'd7;
    retire(5'd7, 32'h77);
    clear = 1'b0;
    check("cl_count", 64'(count),    64'd0);
    check("cl_valid", 64'(tr_valid), 64'd0);
    check("cl_ovf",   64'(overflow), 64'd0);
    check("cl_drop",  64'(drop_cnt), 64'd0);
    check("cl_sh",    64'(sh_data),  64'h77);
    retire(5'd6, 32'h66);
    check("cl_seq",       64'(tr_seq), 64'd11);
    check("cl_post_count", 64'(count), 64'd1);

    // Asynchronous reset mid-cycle with a full FIFO
    for (int i = 0; i < 7; i++) retire(5'd2, 32'h300 + 32'(i));
    check("ar_pre_count", 64'(count),   64'd8);
    check("ar_pre_sh",    64'(sh_data), 64'h77);
    #1;
    reset = 1'b1;
    #1;
    check("ar_valid", 64'(tr_valid), 64'd0);
    check("ar_count", 64'(count),    64'd0);
    check("ar_seq",   64'(tr_seq),   64'd0);
    check("ar_addr",  64'(tr_addr),  64'd0);
    check("ar_data",  64'(tr_data),  64'd0);
    check("ar_sh",    64'(sh_data),  64'd0);
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Retirement trace buffer on the writeback side of `riscv_pipeline`. It captures every register writeback (`wb_e`/`wb_a`/`wb_d`) into a sequence-numbered FIFO, drained through a valid/ready handshake by the test harness or a debug port. It also keeps a shadow copy of the architectural register file, so software-visible register state can be read without reaching into `decode`.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries; power of two, ≥2.
- `SEQ_W`, default 16: width of the retirement sequence number.
- `FILTER_X0`, default 1: when 1, writebacks to x0 are ignored entirely.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `clear`  in  1: synchronous flush of the FIFO and sticky flags; shadow file untouched.
- `wb_e`  in  1: writeback enable from the pipeline.
- `wb_a`  in  5: writeback register address.
- `wb_d`  in  32: writeback data.
- `tr_valid`  out  1: head entry available.
- `tr_ready`  in  1: consumer accepts the head entry.
- `tr_seq`  out  SEQ_W: sequence number of the head entry.
- `tr_addr`  out  5: register address of the head entry.
- `tr_data`  out  32: data of the head entry.
- `count`  out  $clog2(DEPTH)+1: number of occupied entries.
- `overflow`  out  1: sticky; at least one record was dropped because the FIFO was full.
- `drop_cnt`  out  8: dropped-record counter; saturates at 255.
- `sh_addr`  in  5: shadow register-file read address.
- `sh_data`  out  32: shadow read data, registered.

## Operation
- Retire event: `wb_e=1` and not (`FILTER_X0=1` and `wb_a==0`).
- Each retire event:
  - Receives the current `seq`, then `seq` increments, wrapping modulo 2^SEQ_W.
  - Writes the shadow file at `wb_a` with `wb_d`.
  - Pushes {seq, addr, data} into the FIFO.
- Shadow x0 always reads 0, regardless of `FILTER_X0`.
- Pop occurs when `tr_valid && tr_ready`. `tr_*` outputs are driven straight from the head entry (first-word fall-through from storage).
- Full FIFO, retire event, no pop in the same cycle:
  - The record is dropped and `overflow` is set.
  - `drop_cnt` increments, saturating at 255.
  - `seq` still increments, so the consumer sees a gap in sequence numbers.
- Full FIFO with a simultaneous pop: the push is accepted and `count` is unchanged.
- Empty FIFO with a simultaneous push: `tr_valid` stays 0 this cycle. No bypass.
- `clear`:
  - Sets read and write pointers, `count`, `overflow` and `drop_cnt` to 0.
  - Leaves `seq` and the shadow file unchanged.
  - Has priority over a simultaneous push or pop; both are discarded.
  - A retire event in the same cycle still updates the shadow file and `seq`.
- `tr_ready` while `tr_valid=0` has no effect.

## Timing
- Reset values:
  - `tr_valid`=0, `tr_seq`=0, `tr_addr`=0, `tr_data`=0.
  - `count`=0, `overflow`=0, `drop_cnt`=0, `sh_data`=0.
  - `seq`=0 and all 32 shadow registers = 0.
- Reset applies immediately, mid-drain included. Any in-flight record is lost.
- Push-to-visible latency is 1 cycle: a retire event at edge N gives `tr_valid`=1 after edge N.
- Pop takes effect at the edge. The next entry is presented in the following cycle, so back-to-back throughput is 1 record per cycle.
- `sh_data` has 1-cycle latency. Write-then-read of the same register in one cycle returns the new `wb_d` (write-first).
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is decided from `count`.

## Structure
- In `riscv_structures.sv`:
  - `wb_trace_s` packed struct {seq[SEQ_W-1:0], addr[4:0], data[31:0]}, using the default SEQ_W.
  - `TRACE_DROP_MAX` = 8'd255.
- Sub-module `trace_fifo`, parameterised on DEPTH and element type. It owns storage, pointers, `count` and the push/pop/clear priority.
- The top of this block holds the sequence counter, x0 filter, shadow file, overflow logic and drop counter.
- Instantiated beside `riscv_pipeline`, wired to its `wb_e`/`wb_a`/`wb_d` outputs.

## Test plan
- Reset, then 3 retire events (x1=0x11, x2=0x22, x3=0x33) with `tr_ready`=1 → records seq 0/1/2 appear on consecutive cycles, each one cycle after its event; `count` never exceeds 1.
- `tr_ready`=0, 10 retire events into DEPTH=8 → `count`=8, `overflow`=1, `drop_cnt`=2. Draining then yields seq 0..7; the next event gets seq 10.
- `FILTER_X0`=1, write x0=0xDEAD → no FIFO entry, seq unchanged, `sh_addr`=0 reads 0. Write x5=0xCAFE while reading x5 → `sh_data`=0xCAFE next cycle.
- FIFO full, push and pop in the same cycle → `count` stays 8, `overflow` stays 0, pushed record is present after draining.
- `clear` asserted with 4 entries and `overflow`=1 → next cycle `count`=0, `tr_valid`=0, `overflow`=0; a subsequent event gets seq continuing from before the clear.
- Async `reset` pulse mid-cycle with a full FIFO → all outputs 0 immediately, without waiting for a clock edge.
